// File: rtl/fft_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_arbiter_if
// Purpose  : Bundle of the frame-source, FFT-pipeline and output-stream
//            signals of fft_frame_arbiter.
// Modports : slave  - arbiter view (sources/pipeline return in, grants/
//                     pipeline drive/labelled output stream out)
//            master - environment view (the opposite directions)
// Signals  : req0/req1, src{0,1}_{re,im}      frame sources
//            grant0/grant1                    per-source sample strobe
//            fft_en, fft_re, fft_im           pipeline input
//            fft_en_out, fft_out_re/_im       pipeline output
//            out_valid/_re/_im/_src/_last     labelled output stream
//            busy, err_orphan                 status
// Revision : 1.0 - initial release
// ============================================================================
interface fft_frame_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] src0_re;
  logic [WIDTH-1:0] src0_im;
  logic [WIDTH-1:0] src1_re;
  logic [WIDTH-1:0] src1_im;
  logic             grant0;
  logic             grant1;
  logic             fft_en;
  logic [WIDTH-1:0] fft_re;
  logic [WIDTH-1:0] fft_im;
  logic             fft_en_out;
  logic [WIDTH-1:0] fft_out_re;
  logic [WIDTH-1:0] fft_out_im;
  logic             out_valid;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic             out_src;
  logic             out_last;
  logic             busy;
  logic             err_orphan;

  modport slave (
    input  req0, req1, src0_re, src0_im, src1_re, src1_im,
    input  fft_en_out, fft_out_re, fft_out_im,
    output grant0, grant1, fft_en, fft_re, fft_im,
    output out_valid, out_re, out_im, out_src, out_last, busy, err_orphan
  );

  modport master (
    output req0, req1, src0_re, src0_im, src1_re, src1_im,
    output fft_en_out, fft_out_re, fft_out_im,
    input  grant0, grant1, fft_en, fft_re, fft_im,
    input  out_valid, out_re, out_im, out_src, out_last, busy, err_orphan
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_arbiter
// Purpose  : Shares one sdf4 FFT pipeline stage between two frame sources.
//            Whole N-sample frames are granted round-robin as contiguous
//            bursts, each launched frame's source ID is queued in a tag
//            FIFO, and the pipeline output is re-labelled with source ID
//            and end-of-frame.
// Ports    : clk    - clock
//            rst_n  - synchronous active-low reset
//            bus    - fft_frame_arbiter_if.slave (sources, pipeline I/O,
//                     labelled output stream, busy, err_orphan)
// Params   : N (power of 2, >= 4), WIDTH, MAX_OUT (power of 2, >= 2),
//            GAP (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_arbiter #(
  parameter int N       = 64,
  parameter int WIDTH   = 8,
  parameter int MAX_OUT = 4,
  parameter int GAP     = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  fft_frame_arbiter_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int GW = $clog2(GAP + 1);
  localparam int AW = $clog2(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // ---------------- frame launch FSM ----------------
  state_t          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            grant0_q, grant0_d;
  logic            grant1_q, grant1_d;
  logic            rr_q, rr_d;          // 0: source 0 preferred
  logic            w_win;               // ID of the source that would win now
  logic            w_push;

  // ---------------- tag FIFO ----------------
  logic [MAX_OUT-1:0] tag_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        occ_q;
  logic               w_full, w_empty, w_pop;

  // ---------------- datapath / output ----------------
  logic             fft_en_q;
  logic [WIDTH-1:0] fft_re_q, fft_im_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_re_q, out_im_q;
  logic [CW-1:0]    out_cnt_q;
  logic             err_q;
  logic             w_out_last;

  // Grant decision deliberately uses registered occupancy: a pop in the
  // same cycle does not unblock a launch until the next cycle.
  assign w_full  = (occ_q == (AW+1)'(MAX_OUT));
  assign w_empty = (occ_q == '0);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    gap_cnt_d = gap_cnt_q;
    grant0_d  = grant0_q;
    grant1_d  = grant1_q;
    rr_d      = rr_q;
    w_push    = 1'b0;
    w_win     = (bus.req0 && bus.req1) ? rr_q : bus.req1;
    case (state_q)
      S_IDLE: begin
        if ((bus.req0 || bus.req1) && !w_full) begin
          state_d  = S_RUN;
          in_cnt_d = '0;
          grant0_d = ~w_win;
          grant1_d = w_win;
          rr_d     = ~w_win;
          w_push   = 1'b1;
        end
      end
      S_RUN: begin
        if (in_cnt_q == CW'(N - 1)) begin
          grant0_d  = 1'b0;
          grant1_d  = 1'b0;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) state_d = S_IDLE;
        else                           gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      gap_cnt_q <= '0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      rr_q      <= rr_d;
    end
  end

  // Pop on the last output sample; an orphan frame has nothing to pop.
  assign w_out_last = out_valid_q && (out_cnt_q == CW'(N - 1));
  assign w_pop      = w_out_last && !w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (w_push) begin
        tag_q[wr_ptr_q] <= w_win;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fft_en_q    <= 1'b0;
      fft_re_q    <= '0;
      fft_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      fft_en_q    <= grant0_q | grant1_q;
      fft_re_q    <= grant0_q ? bus.src0_re : (grant1_q ? bus.src1_re : '0);
      fft_im_q    <= grant0_q ? bus.src0_im : (grant1_q ? bus.src1_im : '0);
      out_valid_q <= bus.fft_en_out;
      out_re_q    <= bus.fft_out_re;
      out_im_q    <= bus.fft_out_im;
      if (out_valid_q) out_cnt_q <= out_cnt_q + 1'b1;
      if (bus.fft_en_out && w_empty) err_q <= 1'b1;
    end
  end

  assign bus.grant0     = grant0_q;
  assign bus.grant1     = grant1_q;
  assign bus.fft_en     = fft_en_q;
  assign bus.fft_re     = fft_re_q;
  assign bus.fft_im     = fft_im_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_re     = out_re_q;
  assign bus.out_im     = out_im_q;
  assign bus.out_last   = w_out_last;
  assign bus.out_src    = (out_valid_q && !w_empty) ? tag_q[rd_ptr_q] : 1'b0;
  assign bus.busy       = (state_q != S_IDLE) || !w_empty;
  assign bus.err_orphan = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_arbiter
// Purpose  : Self-checking bench for fft_frame_arbiter (N=64, WIDTH=8,
//            MAX_OUT=4, GAP=1). Cycle table plus directed sequences for
//            single frame, round-robin, FIFO-full stall, mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_arbiter;
  localparam int N = 64, WIDTH = 8, MAX_OUT = 4, GAP = 1;

  logic clk, rst_n;
  fft_frame_arbiter_if #(.WIDTH(WIDTH)) bif ();

  fft_frame_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_OUT(MAX_OUT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pipeline input into DUT: manual drive or pipeline model
  logic       manual, man_en, mdl_en;
  logic [7:0] man_re, mdl_re, mdl_im;
  assign bif.fft_en_out = manual ? man_en : mdl_en;
  assign bif.fft_out_re = manual ? man_re : mdl_re;
  assign bif.fft_out_im = manual ? 8'h00  : mdl_im;

  int n_vec, n_err;
  int credits;          // frames the model pipeline may emit since reset
  int n_last;           // out_last events seen
  time last_t;          // time of most recent out_last
  logic [15:0] q_fft[$];
  logic [17:0] q_out[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {bif.grant0, bif.grant1, bif.fft_en, bif.out_valid, bif.out_re,
            bif.out_src, bif.out_last, bif.busy, bif.err_orphan};
  endfunction

  // sources: sample index k within the frame, source 1 offset by 64
  initial begin
    int c0, c1;
    c0 = 0; c1 = 0;
    bif.src0_re = '0; bif.src0_im = '0; bif.src1_re = '0; bif.src1_im = '0;
    forever begin
      step();
      if (bif.grant0) begin bif.src0_re = 8'(c0); bif.src0_im = ~8'(c0); c0++; end
      else begin c0 = 0; bif.src0_re = '0; bif.src0_im = '0; end
      if (bif.grant1) begin bif.src1_re = 8'(c1 + 64); bif.src1_im = ~8'(c1 + 64); c1++; end
      else begin c1 = 0; bif.src1_re = '0; bif.src1_im = '0; end
    end
  end

  // pipeline model: FIFO of accepted samples, released frame by frame
  initial begin
    logic [15:0] pq[$];
    int ecnt, emitted;
    ecnt = 0; emitted = 0; mdl_en = 0; mdl_re = 0; mdl_im = 0;
    forever begin
      step();
      if (!rst_n) begin
        pq.delete(); ecnt = 0; emitted = 0; mdl_en = 0; mdl_re = 0; mdl_im = 0;
      end else begin
        if (bif.fft_en) pq.push_back({bif.fft_re, bif.fft_im});
        if (emitted < credits && pq.size() > 0) begin
          {mdl_re, mdl_im} = pq.pop_front();
          mdl_en = 1'b1;
          ecnt++;
          if (ecnt == N) begin ecnt = 0; emitted++; end
        end else begin
          mdl_en = 0; mdl_re = 0; mdl_im = 0;
        end
      end
    end
  end

  // stream monitor
  initial begin
    n_last = 0; last_t = 0;
    forever begin
      step();
      if (bif.fft_en) q_fft.push_back({bif.fft_re, bif.fft_im});
      if (bif.out_valid) begin
        q_out.push_back({bif.out_src, bif.out_last, bif.out_re, bif.out_im});
        if (bif.out_last) begin n_last++; last_t = $time; end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 0; bif.req0 = 0; bif.req1 = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic wait_grant(input bit which, input int budget, output bit ok);
    int n;
    n = 0;
    while (!(which ? bif.grant1 : bif.grant0) && n < budget) begin step(); n++; end
    ok = which ? bif.grant1 : bif.grant0;
  endtask

  typedef struct {
    logic       rst_n, req0, req1, en;
    logic [7:0] re;
    logic [15:0] exp;  // {g0,g1,fft_en,out_valid,out_re,out_src,out_last,busy,err}
  } vec_t;
  vec_t tbl[10];

  initial begin
    int bf, bo, len, bad, launched, dt, dl, nl0, lasts;
    bit ok, prev, found;
    n_vec = 0; n_err = 0; credits = 0;
    manual = 1; man_en = 0; man_re = 0;
    rst_n = 0; bif.req0 = 0; bif.req1 = 0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};  // reset
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 16'h1111};  // orphan output
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0001};  // err sticky
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0001};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h8003};  // grant0
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hA003};  // fft_en lags
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};  // reset mid-frame
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h4002};  // sole req1
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h6002};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};

    step(); step();
    for (int i = 0; i < 10; i++) begin
      rst_n = tbl[i].rst_n; bif.req0 = tbl[i].req0; bif.req1 = tbl[i].req1;
      man_en = tbl[i].en; man_re = tbl[i].re;
      step();
      check($sformatf("tbl[%0d]", i), {16'h0, obs()}, {16'h0, tbl[i].exp});
    end
    man_en = 0; man_re = 0; manual = 0;

    // ---- single frame from source 0 ----
    do_reset();
    credits = 1000; bf = q_fft.size(); bo = q_out.size();
    check("a_reset_state", {16'h0, obs()}, 32'h0);
    bif.req0 = 1;
    wait_grant(0, 20, ok);
    bif.req0 = 0;
    check("a_grant_seen", {31'h0, ok}, 1);
    check("a_fft_en_lag", {31'h0, bif.fft_en}, 0);
    len = 1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!bif.grant0) break;
      len++;
    end
    check("a_grant_len", len, 64);
    repeat (20) step();
    check("a_fft_count", q_fft.size() - bf, 64);
    bad = 0;
    for (int i = 0; i < 64 && bf + i < q_fft.size(); i++)
      if (q_fft[bf + i] !== {8'(i), ~8'(i)}) bad++;
    check("a_fft_data", bad, 0);
    check("a_out_count", q_out.size() - bo, 64);
    bad = 0;
    for (int i = 0; i < 64 && bo + i < q_out.size(); i++)
      if (q_out[bo + i] !== {1'b0, (i == 63), 8'(i), ~8'(i)}) bad++;
    check("a_out_stream", bad, 0);
    check("a_busy_after", {31'h0, bif.busy}, 0);

    // ---- both sources requesting: round robin ----
    do_reset();
    credits = 1000; bo = q_out.size();
    bif.req0 = 1; bif.req1 = 1;
    for (int f = 0; f < 4; f++) begin
      len = 0;
      while (!(bif.grant0 || bif.grant1) && len < 100) begin step(); len++; end
      if (f == 3) begin bif.req0 = 0; bif.req1 = 0; end
      check($sformatf("b_grant_id[%0d]", f), {30'h0, bif.grant1, bif.grant0},
            (f % 2) ? 32'd2 : 32'd1);
      if (f > 0) check($sformatf("b_idle_gap[%0d]", f), len, GAP + 1);
      for (int k = 0; k < 100 && (bif.grant0 || bif.grant1); k++) step();
    end
    repeat (80) step();
    check("b_out_count", q_out.size() - bo, 256);
    bad = 0;
    for (int i = 0; i < 256 && bo + i < q_out.size(); i++)
      if (q_out[bo + i] !== {1'((i / 64) % 2), ((i % 64) == 63),
                             8'(((i / 64) % 2) * 64 + i % 64),
                             ~8'(((i / 64) % 2) * 64 + i % 64)}) bad++;
    check("b_out_stream", bad, 0);
    check("b_busy_after", {31'h0, bif.busy}, 0);

    // ---- output withheld: MAX_OUT frames then stall ----
    do_reset();
    credits = 0; bif.req0 = 1; launched = 0; prev = 0;
    for (int k = 0; k < 450; k++) begin
      step();
      if (bif.grant0 && !prev) launched++;
      prev = bif.grant0;
    end
    check("c_launched", launched, MAX_OUT);
    check("c_stalled", {30'h0, bif.grant0, bif.busy}, 32'd1);
    nl0 = n_last; found = 0; dt = 0; dl = 0;
    credits = 1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (bif.grant0 && !prev) begin
        found = 1; dt = int'(($time - last_t) / 10); dl = n_last - nl0;
        break;
      end
      prev = bif.grant0;
    end
    bif.req0 = 0;
    check("c_regrant_seen", {31'h0, found}, 1);
    check("c_regrant_after_last", dl, 1);
    check("c_regrant_delay_ge2", {31'h0, (dt >= 2)}, 1);

    // ---- reset at sample 20 of a frame ----
    do_reset();
    credits = 1000;
    bif.req0 = 1;
    wait_grant(0, 20, ok);
    bif.req0 = 0;
    repeat (20) step();
    check("d_mid_frame", {29'h0, bif.grant0, bif.fft_en, bif.busy}, 32'd7);
    rst_n = 0;
    step();
    check("d_after_reset", {16'h0, obs()}, 32'h0);
    step();
    rst_n = 1;
    bo = q_out.size();
    bif.req1 = 1;
    wait_grant(1, 20, ok);
    bif.req1 = 0;
    check("d_req1_granted", {30'h0, ok, bif.grant0}, 32'd2);
    repeat (100) step();
    lasts = 0; bad = 0;
    for (int i = bo; i < q_out.size(); i++) begin
      if (q_out[i][17] !== 1'b1) bad++;
      if (q_out[i][16]) lasts++;
    end
    check("d_out_count", q_out.size() - bo, 64);
    check("d_out_src1", {bad[15:0], lasts[15:0]}, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
